// File: rtl/slave_serial_port_if.sv
// Serial bus between a master and one slave port.
interface slave_serial_port_if;
  logic mvalid;
  logic mwdata;
  logic mmode;
  logic sready;
  logic svalid;
  logic srdata;

  modport master (
    output mvalid, mwdata, mmode,
    input  sready, svalid, srdata
  );

  modport slave (
    input  mvalid, mwdata, mmode,
    output sready, svalid, srdata
  );
endinterface

// File: rtl/slave_serial_port.sv
// Slave-side serial port: deserialises address/write data into a memory
// request and serialises read data back to the master, LSB first.
module slave_serial_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_serial_port_if.slave    sbus,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       RD_ACCEPT = 2'd2;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, READ, RDATA} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            rd_cnt_q, rd_cnt_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  shift_addr, shift_data, load_tx, shift_tx;

  // State, bit counter and read-cycle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Next-state, counter and datapath-control decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = '0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sbus.mvalid) begin
          shift_addr = 1'b1;
          cnt_d      = CNT_ONE;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (sbus.mvalid) begin
          shift_addr = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? WDATA : READ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      WDATA: begin
        if (sbus.mvalid) begin
          shift_data = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        // rvalid before the third READ cycle cannot belong to this request
        rd_cnt_d = (rd_cnt_q == RD_ACCEPT) ? RD_ACCEPT : rd_cnt_q + 2'd1;
        if ((rd_cnt_q == RD_ACCEPT) && mem_rvalid) begin
          load_tx  = 1'b1;
          cnt_d    = '0;
          rd_cnt_d = '0;
          state_d  = RDATA;
        end
      end
      RDATA: begin
        shift_tx = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mode latch and address/write-data/read-data shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
    end else begin
      if ((state_q == IDLE) && sbus.mvalid) begin
        mode_q <= sbus.mmode;
      end
      if (shift_addr) begin
        addr_q <= {sbus.mwdata, addr_q[ADDR_WIDTH-1:1]};
      end
      if (shift_data) begin
        wdata_q <= {sbus.mwdata, wdata_q[DATA_WIDTH-1:1]};
      end
      if (load_tx) begin
        tx_q <= mem_rdata;
      end else if (shift_tx) begin
        tx_q <= {1'b0, tx_q[DATA_WIDTH-1:1]};
      end
    end
  end

  assign sbus.sready = (state_q == IDLE);
  assign sbus.svalid = (state_q == RDATA);
  assign sbus.srdata = tx_q[0];
  assign mem_wen     = (state_q == WRITE);
  assign mem_ren     = (state_q == READ);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
